// File: rtl/alu_writeback_if.sv
// ALU-to-writeback bundle: ALU result/status in, register-file write port out,
// plus PSR and queue occupancy observation.
interface alu_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_carry;
    logic              in_low;
    logic              in_flag;
    logic              in_negative;
    logic              in_zero;
    logic [ADDR_W-1:0] in_dest;
    logic              in_wr_en;
    logic              in_flags_en;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;

    logic [4:0]        psr;
    logic              carry_q;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_result, in_carry, in_low, in_flag, in_negative, in_zero,
        input  in_dest, in_wr_en, in_flags_en, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata, psr, carry_q, count
    );

    modport master (
        output in_valid, in_result, in_carry, in_low, in_flag, in_negative, in_zero,
        output in_dest, in_wr_en, in_flags_en, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata, psr, carry_q, count
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: small in-order write queue toward the register file
// and the processor status register fed by the ALU status outputs.
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic           clk,
    input  logic           reset,
    alu_writeback_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        psr_q, psr_d;

    logic in_ready;
    logic rf_we;
    logic accept;
    logic push;
    logic pop;

    // Ready is a pure function of occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign rf_we    = (count_q != '0);
    assign accept   = bus.in_valid && in_ready;
    assign push     = accept && bus.in_wr_en;
    assign pop      = rf_we && bus.rf_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        psr_d    = psr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (accept && bus.in_flags_en) begin
            psr_d = {bus.in_negative, bus.in_zero, bus.in_flag, bus.in_low, bus.in_carry};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            psr_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            psr_q    <= psr_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            dest_mem_q[wr_ptr_q] <= bus.in_dest;
            data_mem_q[wr_ptr_q] <= bus.in_result;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = dest_mem_q[rd_ptr_q];
    assign bus.rf_wdata = data_mem_q[rd_ptr_q];
    assign bus.psr      = psr_q;
    assign bus.carry_q  = psr_q[0];
    assign bus.count    = count_q;
endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_alu_writeback;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    logic clk;
    logic reset;

    alu_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending writes in acceptance order, plus the PSR.
    logic [ADDR_W+DATA_W-1:0] mq[$];
    logic [4:0]               mpsr = '0;

    task automatic set_in(input bit v, input logic [DATA_W-1:0] r, input logic [ADDR_W-1:0] d,
                          input bit we, input bit fe, input logic [4:0] st);
        bus.in_valid    = v;
        bus.in_result   = r;
        bus.in_dest     = d;
        bus.in_wr_en    = we;
        bus.in_flags_en = fe;
        {bus.in_negative, bus.in_zero, bus.in_flag, bus.in_low, bus.in_carry} = st;
    endtask

    task automatic tick();
        bit acc;
        bit pp;
        acc = bus.in_valid && (mq.size() < DEPTH);
        pp  = (mq.size() != 0) && bus.rf_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            mpsr = '0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc && bus.in_wr_en) mq.push_back({bus.in_dest, bus.in_result});
            if (acc && bus.in_flags_en)
                mpsr = {bus.in_negative, bus.in_zero, bus.in_flag, bus.in_low, bus.in_carry};
        end
    endtask

    task automatic test_reset();
        set_in(0, '0, '0, 0, 0, '0);
        bus.rf_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0b expected 0", bus.rf_we); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        n_checks++;
        if (bus.psr !== 5'b0 || bus.carry_q !== 1'b0) begin
            n_fail++; $display("FAIL reset_psr: got %05b/%0b expected 00000/0", bus.psr, bus.carry_q);
        end
    endtask

    task automatic test_basic();
        bus.rf_ready = 1'b1;
        set_in(1, 16'h1234, 4'd3, 1, 1, 5'b00001);
        tick();
        set_in(0, '0, '0, 0, 0, '0);
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd3 || bus.rf_wdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_write: got we=%0b addr=%0d data=%h expected we=1 addr=3 data=1234",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.psr !== 5'b00001 || bus.carry_q !== 1'b1) begin
            n_fail++; $display("FAIL basic_psr: got %05b/%0b expected 00001/1", bus.psr, bus.carry_q);
        end
        tick();
        n_checks++;
        if (bus.count !== '0 || bus.rf_we !== 1'b0) begin
            n_fail++; $display("FAIL basic_drain: got count=%0d we=%0b expected 0/0", bus.count, bus.rf_we);
        end
    endtask

    task automatic test_backpressure();
        bus.rf_ready = 1'b0;
        set_in(1, 16'h0001, 4'd1, 1, 0, '0);
        tick();
        set_in(1, 16'h0002, 4'd2, 1, 0, '0);
        tick();
        set_in(1, 16'h0003, 4'd3, 1, 0, '0);
        n_checks++;
        if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: got count=%0d ready=%0b expected 2/0", bus.count, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.count !== 2'd2 || bus.rf_wdata !== 16'h0001) begin
            n_fail++; $display("FAIL bp_reject: got count=%0d head=%h expected 2/0001", bus.count, bus.rf_wdata);
        end
        bus.rf_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_comb: got %0b expected 0", bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.count !== 2'd1 || bus.rf_wdata !== 16'h0002 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second: got count=%0d head=%h ready=%0b expected 1/0002/1",
                               bus.count, bus.rf_wdata, bus.in_ready);
        end
        tick();
        set_in(0, '0, '0, 0, 0, '0);
        n_checks++;
        if (bus.count !== 2'd1 || bus.rf_wdata !== 16'h0003 || bus.rf_waddr !== 4'd3) begin
            n_fail++; $display("FAIL bp_third: got count=%0d head=%h addr=%0d expected 1/0003/3",
                               bus.count, bus.rf_wdata, bus.rf_waddr);
        end
        tick();
    endtask

    task automatic test_flags_only();
        bus.rf_ready = 1'b1;
        set_in(1, 16'hFFFF, 4'd7, 0, 1, 5'b01000);
        tick();
        set_in(0, '0, '0, 0, 0, '0);
        n_checks++;
        if (bus.psr !== 5'b01000 || bus.count !== '0 || bus.rf_we !== 1'b0) begin
            n_fail++; $display("FAIL flags_only: got psr=%05b count=%0d we=%0b expected 01000/0/0",
                               bus.psr, bus.count, bus.rf_we);
        end
        // No accept while full: psr must hold.
        bus.rf_ready = 1'b0;
        set_in(1, 16'hA, 4'd1, 1, 0, '0); tick();
        set_in(1, 16'hB, 4'd2, 1, 0, '0); tick();
        set_in(1, 16'hC, 4'd3, 1, 1, 5'b10111); tick();
        set_in(0, '0, '0, 0, 0, '0);
        n_checks++;
        if (bus.psr !== 5'b01000) begin
            n_fail++; $display("FAIL flags_blocked: got %05b expected 01000", bus.psr);
        end
        bus.rf_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_push_pop();
        logic [DATA_W-1:0] v;
        bus.rf_ready = 1'b1;
        set_in(1, 16'h00A0, 4'd10, 1, 0, '0);
        tick();
        for (int i = 0; i < 6; i++) begin
            v = DATA_W'(16'h0B00 + i);
            set_in(1, v, ADDR_W'(i), 1, 0, '0);
            tick();
            n_checks++;
            if (bus.count !== 2'd1 || bus.rf_wdata !== v || bus.rf_waddr !== ADDR_W'(i)) begin
                n_fail++; $display("FAIL push_pop_%0d: got count=%0d data=%h addr=%0d expected 1/%h/%0d",
                                   i, bus.count, bus.rf_wdata, bus.rf_waddr, v, i);
            end
        end
        set_in(0, '0, '0, 0, 0, '0);
        tick();
    endtask

    task automatic test_stall_hold();
        bus.rf_ready = 1'b0;
        set_in(1, 16'hBEEF, 4'd5, 1, 0, '0);
        tick();
        set_in(0, '0, '0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd5 || bus.rf_wdata !== 16'hBEEF) begin
                n_fail++; $display("FAIL stall_hold_%0d: got we=%0b addr=%0d data=%h expected 1/5/beef",
                                   i, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
            end
            tick();
        end
        bus.rf_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL stall_release: got we=%0b expected 0", bus.rf_we); end
    endtask

    task automatic test_reset_midstream();
        bus.rf_ready = 1'b0;
        set_in(1, 16'h1111, 4'd1, 1, 1, 5'b11111); tick();
        set_in(1, 16'h2222, 4'd2, 1, 0, '0); tick();
        n_checks++;
        if (bus.count !== 2'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", bus.count); end
        reset = 1'b1;
        bus.rf_ready = 1'b1;
        set_in(1, 16'h3333, 4'd3, 1, 1, 5'b10101);
        tick();
        reset = 1'b0;
        set_in(0, '0, '0, 0, 0, '0);
        n_checks++;
        if (bus.count !== '0 || bus.psr !== 5'b0 || bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got count=%0d psr=%05b we=%0b ready=%0b expected 0/00000/0/1",
                               bus.count, bus.psr, bus.rf_we, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.count !== '0 || bus.rf_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: got count=%0d we=%0b expected 0/0", bus.count, bus.rf_we);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W+DATA_W-1:0] h;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.rf_ready = ($urandom_range(0, 2) != 0);
            set_in($urandom_range(0, 3) != 0, DATA_W'($urandom), ADDR_W'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1, 5'($urandom));
            tick();
            n_checks++;
            if (int'(bus.count) !== mq.size() || bus.rf_we !== (mq.size() != 0)
                || bus.in_ready !== (mq.size() < DEPTH)) begin
                n_fail++; $display("FAIL rand_occ_%0d: got count=%0d we=%0b ready=%0b expected count=%0d",
                                   i, bus.count, bus.rf_we, bus.in_ready, mq.size());
            end
            n_checks++;
            if (bus.psr !== mpsr || bus.carry_q !== mpsr[0]) begin
                n_fail++; $display("FAIL rand_psr_%0d: got %05b/%0b expected %05b", i, bus.psr, bus.carry_q, mpsr);
            end
            if (mq.size() != 0) begin
                h = mq[0];
                n_checks++;
                if ({bus.rf_waddr, bus.rf_wdata} !== h) begin
                    n_fail++; $display("FAIL rand_head_%0d: got %h expected %h", i, {bus.rf_waddr, bus.rf_wdata}, h);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.rf_ready = 1'b0;
        set_in(0, '0, '0, 0, 0, '0);
        test_reset();
        test_basic();
        test_backpressure();
        test_flags_only();
        test_push_pop();
        test_stall_hold();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16, result width.
REQ-002 SHALL have parameter ADDR_W, default 4, register-file write address width.
REQ-003 SHALL have parameter DEPTH, default 2, write-queue entries; power of two, >= 2.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  ALU result presented this cycle.
REQ-007 in_ready  output  1  block accepts the presented result.
REQ-008 in_result  input  DATA_W  ALU result C.
REQ-009 in_carry, in_low, in_flag, in_negative, in_zero  input  1 each  ALU status outputs.
REQ-010 in_dest  input  ADDR_W  destination register.
REQ-011 in_wr_en  input  1  result is written to the register file.
REQ-012 in_flags_en  input  1  status bits update the PSR.
REQ-013 rf_we  output  1  register-file write request (queue head valid).
REQ-014 rf_waddr  output  ADDR_W  head destination.
REQ-015 rf_wdata  output  DATA_W  head result.
REQ-016 rf_ready  input  1  register file accepts the write this cycle.
REQ-017 psr  output  5  {Negative, Zero, Flag, Low, Carry}, bit 4 down to bit 0.
REQ-018 carry_q  output  1  equals psr[0]; drives ALU CarryIn.
REQ-019 count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 Accept SHALL occur when in_valid && in_ready are both high at a rising edge.
REQ-021 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend combinationally on rf_ready.
REQ-022 On accept with in_wr_en=1, {in_dest, in_result} SHALL be pushed at the queue tail.
REQ-023 On accept with in_wr_en=0, nothing SHALL be pushed.
REQ-024 On accept with in_flags_en=1, psr SHALL load the five status inputs at that edge, visible in the next cycle.
REQ-025 psr SHALL hold its value when there is no accept or when in_flags_en=0.
REQ-026 rf_we SHALL equal (count != 0); rf_waddr and rf_wdata SHALL present the head entry and SHALL be stable while rf_we && !rf_ready.
REQ-027 A pop SHALL occur when rf_we && rf_ready at a rising edge.
REQ-028 Writes SHALL leave in strict acceptance order; latency from accept into an empty queue to rf_we is 1 cycle.
REQ-029 Simultaneous push and pop SHALL leave count unchanged and retain both entries' order.
REQ-030 At count=DEPTH, a same-cycle pop SHALL NOT raise in_ready in that cycle; in_ready rises in the next cycle.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 rf_we=0 SHALL force a pop to be ignored; rf_ready with an empty queue SHALL have no effect.
REQ-033 in_valid while in_ready=0 SHALL neither push nor update psr.

Reset
REQ-034 While reset=1 at a rising edge: count=0, pointers=0, psr=5'b0, carry_q=0, rf_we=0, in_ready=1 from the following cycle.
REQ-035 Reset mid-operation SHALL discard all queued writes; no rf_we SHALL assert in the cycle after reset.
REQ-036 A concurrent accept or pop in a reset cycle SHALL be ignored.

Verification
REQ-037 Basic: accept result 16'h1234, dest 3, wr_en=1, flags_en=1, Z=0, N=0, C=1 with rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234, psr=5'b00001, carry_q=1; the cycle after that, count=0.
REQ-038 Back-pressure: rf_ready=0, accept 16'h0001, 16'h0002, then offer 16'h0003 -> count=2, in_ready=0, 16'h0003 not accepted; raise rf_ready -> writes 0001 then 0002 in order, then 0003 accepted.
REQ-039 Flags-only: accept with wr_en=0, flags_en=1, Z=1 -> psr=5'b01000, count unchanged, no rf_we.
REQ-040 Push/pop: count=1, rf_ready=1, accept a new result -> count stays 1, next write is the new result; wrap covered over 5 consecutive writes.
REQ-041 Reset mid-stream: count=2, assert reset one cycle -> count=0, psr=0, rf_we=0 the following cycle, in_ready=1.
REQ-042 Stall hold: rf_ready=0 for 3 cycles with head {5, 16'hBEEF} -> rf_waddr and rf_wdata unchanged throughout.
